// File: rtl/tconv_pkg.sv
// Shared types and sizing helpers for the streaming transposed-convolution layer.
// Contents: FSM state enum, derived-size functions (UP, P, OUT_WIDTH), accumulator
// width and a generic signed saturation helper.
package tconv_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_e;

    // Side of the zero-inserted grid.
    function automatic int unsigned up_size(input int unsigned in_w, input int unsigned stride);
        return (in_w - 1) * stride + 1;
    endfunction

    // Side of the zero-inserted grid plus K-1 zero padding on each side.
    function automatic int unsigned pad_size(input int unsigned up, input int unsigned k);
        return up + 2 * (k - 1);
    endfunction

    function automatic int unsigned out_size(input int unsigned up, input int unsigned k);
        return up + k - 1;
    endfunction

    // Full-precision sum of K*K products of two DW-bit signed values.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned k);
        return 2 * dw + $clog2(k * k);
    endfunction

    // Clamp v into the signed range of a w-bit value.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/tconv_mac_pipe.sv
// Three-stage KxK multiply-accumulate pipeline with bias, rounding-down rescale and
// saturation. Optional fused ReLU when TCONV_RELU_EN is defined (same latency).
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   en_i               global advance enable; all stages hold when low
//   valid_i            current window is a real output window
//   win_i, w_i         K*K samples / weights, element i at [i*DW +: DW]
//   bias_i             signed bias in the same Q format as the samples
//   valid_o, data_o    registered result and its valid
//   busy_o             a result is still travelling through S1 or S2
module tconv_mac_pipe
    import tconv_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned K         = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [K*K*DW-1:0] win_i,
    input  logic [K*K*DW-1:0] w_i,
    input  logic [DW-1:0]     bias_i,
    output logic              valid_o,
    output logic [DW-1:0]     data_o,
    output logic              busy_o
);
    localparam int unsigned N   = K * K;
    localparam int unsigned PW  = 2 * DW;
    localparam int unsigned ACC = acc_width(DW, K);

    logic signed [PW-1:0]  prod_d [N];
    logic signed [PW-1:0]  prod_q [N];
    logic signed [ACC-1:0] sum_d;
    logic signed [ACC-1:0] sum_q;
    logic signed [ACC-1:0] shifted;
    logic signed [63:0]    sat;
    logic [DW-1:0]         res_d;
    logic [DW-1:0]         res_q;
    logic                  v1_q, v2_q, v3_q;

    // S1: element-wise products.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            prod_d[i] = PW'($signed(win_i[i*DW +: DW])) * PW'($signed(w_i[i*DW +: DW]));
        end
    end

    // S2: adder tree seeded with the bias aligned to the product's fraction position.
    always_comb begin
        sum_d = ACC'($signed(bias_i)) <<< FRAC_BITS;
        for (int i = 0; i < int'(N); i++) begin
            sum_d = sum_d + ACC'(prod_q[i]);
        end
    end

    // S3: arithmetic shift floors toward -inf, then clamp to DW bits.
    always_comb begin
        shifted = sum_q >>> FRAC_BITS;
        sat     = saturate(64'(shifted), DW);
        res_d   = sat[DW-1:0];
`ifdef TCONV_RELU_EN
        if (sat < 0) res_d = '0;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(N); i++) prod_q[i] <= '0;
            sum_q <= '0;
            res_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
        end else if (en_i) begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
            if (v2_q) res_q <= res_d;
            v1_q   <= valid_i;
            v2_q   <= v1_q;
            v3_q   <= v2_q;
        end
    end

    assign valid_o = v3_q;
    assign data_o  = res_q;
    assign busy_o  = v1_q | v2_q;

endmodule

// File: rtl/trans_conv2d_stream_layer.sv
// Streaming single-channel transposed-convolution layer. Scans the zero-inserted,
// zero-padded grid in raster order, feeds a KxK window built from K-1 line buffers
// into a 3-stage MAC, and emits OUT_WIDTH x OUT_WIDTH outputs per input frame.
// Optional build macro: TCONV_RELU_EN (fused ReLU in the final MAC stage).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data   input pixel stream (raster order, handshake)
//   w_flat, bias             pre-flipped weights (w[r*K+c]) and bias, static per frame
//   out_valid/out_ready/out_data output pixel stream (raster order, handshake)
//   frame_done               pulses when the last output of a frame is accepted
module trans_conv2d_stream_layer
    import tconv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned STRIDE     = 2,
    parameter int unsigned K          = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [K*K*DATA_WIDTH-1:0]  w_flat,
    input  logic [DATA_WIDTH-1:0]      bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       frame_done
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned UP = up_size(IN_WIDTH, STRIDE);
    localparam int unsigned P  = pad_size(UP, K);
    localparam int unsigned CW = $clog2(P);

    state_e            state_q;
    logic [CW-1:0]     pr_q, pc_q;
    logic              en, is_real, step, win_valid, mac_busy, last_out;
    logic [DW-1:0]     push_data;
    logic [DW-1:0]     lb_q  [K-1][P];
    logic [DW-1:0]     win_q [K][K];
    logic [DW-1:0]     win_d [K][K];
    logic [DW-1:0]     col   [K];
    logic [K*K*DW-1:0] win_flat;

    assign en = !(out_valid && !out_ready);

    // A position carries an input sample only inside the unpadded area on the stride lattice.
    always_comb begin : decode
        int row_off;
        int col_off;
        row_off = int'(pr_q) - (int'(K) - 1);
        col_off = int'(pc_q) - (int'(K) - 1);
        is_real = (row_off >= 0) && (row_off < int'(UP)) && (row_off % int'(STRIDE) == 0) &&
                  (col_off >= 0) && (col_off < int'(UP)) && (col_off % int'(STRIDE) == 0);
    end

    assign in_ready  = en && (state_q == SCAN) && is_real;
    assign step      = en && (state_q == SCAN) && (!is_real || in_valid);
    assign push_data = is_real ? in_data : '0;
    assign win_valid = step && (pr_q >= CW'(K - 1)) && (pc_q >= CW'(K - 1));

    // Next window = current window shifted left plus the column ending at the pushed sample.
    // Row 0 of the window is the oldest line.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < int'(K) - 1; r++) col[r] = lb_q[int'(K) - 2 - r][pc_q];
        col[K-1] = push_data;
        for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K) - 1; c++) win_d[r][c] = win_q[r][c+1];
            win_d[r][K-1] = col[r];
        end
        for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K); c++) begin
                win_flat[(r*int'(K)+c)*int'(DW) +: DW] = win_d[r][c];
            end
        end
    end

    // Line buffers need no clear: the padded top rows overwrite them with zeros each frame.
    always_ff @(posedge clk) begin
        if (step) begin
            lb_q[0][pc_q] <= push_data;
            for (int j = 1; j < int'(K) - 1; j++) lb_q[j][pc_q] <= lb_q[j-1][pc_q];
            win_q <= win_d;
        end
    end

    // The final output is the one leaving S3 in FLUSH with nothing left behind it.
    assign last_out   = (state_q == FLUSH) && out_valid && out_ready && !mac_busy;
    assign frame_done = last_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pr_q    <= '0;
            pc_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: state_q <= SCAN;
                SCAN: begin
                    if (step) begin
                        if (pc_q == CW'(P - 1)) begin
                            pc_q <= '0;
                            if (pr_q == CW'(P - 1)) begin
                                pr_q    <= '0;
                                state_q <= FLUSH;
                            end else begin
                                pr_q <= pr_q + 1'b1;
                            end
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (last_out) begin
                        state_q <= SCAN;
                        pr_q    <= '0;
                        pc_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tconv_mac_pipe #(
        .DW        (DW),
        .FRAC_BITS (FRAC_BITS),
        .K         (K)
    ) u_mac (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .valid_i (win_valid),
        .win_i   (win_flat),
        .w_i     (w_flat),
        .bias_i  (bias),
        .valid_o (out_valid),
        .data_o  (out_data),
        .busy_o  (mac_busy)
    );

endmodule
